// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S transmit/receive blocks: channel masks,
// controller states and the effective sample-size rule.
package i2s_pkg;

  // Slot-enable masks; bit 1 gates the left (ws=0) slot, bit 0 the right (ws=1) slot
  localparam logic [1:0] CH_LEFT   = 2'b10;
  localparam logic [1:0] CH_RIGHT  = 2'b01;
  localparam logic [1:0] CH_STEREO = 2'b11;

  typedef enum logic [1:0] {
    StIdle,
    StSync,
    StActive
  } state_e;

  // Zero or anything above 32 means a full 32-bit sample
  function automatic logic [5:0] eff_size(input logic [5:0] size);
    if ((size == 6'd0) || (size > 6'd32)) begin
      return 6'd32;
    end
    return size;
  endfunction

endpackage

// File: rtl/i2s_edge_sync.sv
// Multi-flop synchronizer followed by an edge register. Produces the synchronized
// level plus one-cycle rise/fall pulses, all in the clk domain.
module i2s_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Synchronizer chain and edge register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Edge pulses compare the newest synchronized value with the previous one
  always_comb begin
    level = sync_q[SYNC_STAGES-1];
    rise  = level & ~prev_q;
    fall  = ~level & prev_q;
  end

endmodule

// File: rtl/i2s_tx.sv
// I2S slave transmitter: follows an external sck/ws, serializes words from a
// one-entry holding register onto sd, MSB first, left-justified or I2S timing.
module i2s_tx
  import i2s_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sck,
  input  logic        ws,
  output logic        sd,
  input  logic        en,
  input  logic        left_justified,
  input  logic [5:0]  sample_size,
  input  logic [1:0]  channels,
  input  logic [31:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        underflow,
  output logic        busy
);

  logic sck_level, sck_rise, sck_fall;
  logic ws_level, ws_rise, ws_fall;

  i2s_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sck_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (sck),
    .level(sck_level),
    .rise (sck_rise),
    .fall (sck_fall)
  );

  i2s_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_ws_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (ws),
    .level(ws_level),
    .rise (ws_rise),
    .fall (ws_fall)
  );

  state_e      state_q, state_d;
  logic        ws_q;
  logic        boundary;
  logic        act;
  logic        pend_q, pend_d;
  logic        chan_q, chan_d;
  logic        start_ch;
  logic        slot_start;
  logic        slot_on;
  logic        load;
  logic        accept;
  logic        rdy_en_q;
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] shift_q, shift_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [5:0]  size_q, size_d;
  logic        sd_q, sd_d;
  logic        uf_q, uf_d;

  // ws is only meaningful at sck falls; remember the last sampled value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ws_q <= 1'b0;
    end else if (sck_fall) begin
      ws_q <= ws_level;
    end
  end

  // Slot-start decode; a SYNC-state boundary is handled as the first real slot
  always_comb begin
    boundary   = sck_fall & (ws_level != ws_q);
    act        = en & ((state_q == StActive) | ((state_q == StSync) & boundary));
    start_ch   = pend_q ? chan_q : ws_level;
    slot_start = act & sck_fall & (pend_q | (boundary & left_justified));
    slot_on    = start_ch ? |(channels & CH_RIGHT) : |(channels & CH_LEFT);
    load       = slot_start & slot_on & hold_valid_q;
    tx_ready   = rdy_en_q & (~hold_valid_q | load);
    accept     = tx_valid & tx_ready;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (en) state_d = StSync;
      StSync: begin
        if (!en) begin
          state_d = StIdle;
        end else if (boundary) begin
          state_d = StActive;
        end
      end
      StActive: if (!en) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    busy = (state_q == StActive);
  end

  // Holding register: a same-cycle load and accept leaves it full with the new word
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_d       = hold_q;
    if (load) begin
      hold_valid_d = 1'b0;
    end
    if (accept) begin
      hold_valid_d = 1'b1;
      hold_d       = tx_data;
    end
  end

  // Serializer next state
  always_comb begin
    shift_d = shift_q;
    cnt_d   = cnt_q;
    size_d  = size_q;
    sd_d    = sd_q;
    pend_d  = pend_q;
    chan_d  = chan_q;
    uf_d    = 1'b0;
    if (!act) begin
      shift_d = '0;
      cnt_d   = '0;
      sd_d    = 1'b0;
      pend_d  = 1'b0;
    end else if (sck_fall) begin
      if (boundary) begin
        chan_d = ws_level;
      end
      pend_d = boundary & ~left_justified;
      if (slot_start) begin
        size_d  = eff_size(sample_size);
        // Left-align so bit size-1 of the word becomes bit 31
        shift_d = load ? (hold_q << (6'd32 - size_d)) : '0;
        cnt_d   = 6'd1;
        sd_d    = shift_d[31];
        uf_d    = slot_on & ~hold_valid_q;
      end else if (boundary & ~left_justified) begin
        // I2S delay bit: the previous bit stays on the line
        sd_d = sd_q;
      end else if (cnt_q < size_q) begin
        shift_d = {shift_q[30:0], 1'b0};
        cnt_d   = cnt_q + 6'd1;
        sd_d    = shift_d[31];
      end else begin
        sd_d = 1'b0;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q     <= 1'b0;
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
      shift_q      <= '0;
      cnt_q        <= '0;
      size_q       <= 6'd32;
      sd_q         <= 1'b0;
      pend_q       <= 1'b0;
      chan_q       <= 1'b0;
      uf_q         <= 1'b0;
    end else begin
      rdy_en_q     <= 1'b1;
      hold_valid_q <= hold_valid_d;
      hold_q       <= hold_d;
      shift_q      <= shift_d;
      cnt_q        <= cnt_d;
      size_q       <= size_d;
      sd_q         <= sd_d;
      pend_q       <= pend_d;
      chan_q       <= chan_d;
      uf_q         <= uf_d;
    end
  end

  // Registered outputs
  always_comb begin
    sd        = sd_q;
    underflow = uf_q;
  end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: acts as the I2S master (sck/ws), feeds the stream
// from a queue and captures sd at every sck rise, one word per slot.
module tb_i2s_tx;

  localparam int H = 8;  // sck half-period in clk cycles

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sck;
  logic        ws;
  logic        sd;
  logic        en;
  logic        left_justified;
  logic [5:0]  sample_size;
  logic [1:0]  channels;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        underflow;
  logic        busy;

  int          total = 0;
  int          bad = 0;
  int          uf_cnt = 0;
  logic        fire = 1'b0;
  logic [31:0] txq[$];
  logic [31:0] cap[0:15];

  i2s_tx #(
    .SYNC_STAGES(2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sck           (sck),
    .ws            (ws),
    .sd            (sd),
    .en            (en),
    .left_justified(left_justified),
    .sample_size   (sample_size),
    .channels      (channels),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .underflow     (underflow),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (underflow === 1'b1) uf_cnt++;

  // Stream source: present queue head, pop after each handshake
  initial begin
    tx_valid = 1'b0;
    tx_data  = '0;
    forever begin
      @(negedge clk);
      if (fire) void'(txq.pop_front());
      tx_valid = (txq.size() > 0);
      tx_data  = tx_valid ? txq[0] : 32'h0;
      #1;
      fire = tx_valid & tx_ready;
    end
  end

  // Master: n slots of len bits; ws toggles on the first fall of each slot
  task automatic run_slots(input int n, input int len);
    for (int s = 0; s < n; s++) begin
      cap[s] = '0;
      for (int b = 0; b < len; b++) begin
        @(negedge clk);
        sck = 1'b0;
        if (b == 0) ws = ~ws;
        repeat (H) @(negedge clk);
        cap[s] = {cap[s][30:0], sd};
        sck = 1'b1;
        repeat (H - 1) @(negedge clk);
      end
    end
  endtask

  task automatic stop_block();
    en = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    total++; if (sd !== 1'b0) begin bad++; $display("FAIL rst_sd got=%b want=0", sd); end
    total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", tx_ready); end
    total++; if (underflow !== 1'b0) begin bad++; $display("FAIL rst_uf got=%b want=0", underflow); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready got=%b want=1", tx_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_rst_busy got=%b want=0", busy); end
  endtask

  task automatic test_lj_stereo();
    logic [15:0] exp_w [4];
    int          base;
    exp_w = '{16'h1234, 16'hABCD, 16'h0F0F, 16'hF0F0};
    left_justified = 1'b1; sample_size = 6'd16; channels = 2'b11;
    for (int i = 0; i < 4; i++) txq.push_back({16'h0, exp_w[i]});
    base = uf_cnt;
    repeat (4) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    run_slots(4, 16);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (cap[i][15:0] !== exp_w[i]) begin
        bad++; $display("FAIL lj_slot%0d got=%h want=%h", i, cap[i][15:0], exp_w[i]);
      end
    end
    total++; if (uf_cnt != base) begin bad++; $display("FAIL lj_uf got=%0d want=0", uf_cnt - base); end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL lj_busy got=%b want=1", busy); end
    stop_block();
  endtask

  task automatic test_i2s_mode();
    int base;
    left_justified = 1'b0; sample_size = 6'd8; channels = 2'b11;
    txq.push_back(32'h80); txq.push_back(32'h81);
    base = uf_cnt;
    repeat (4) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    run_slots(2, 16);
    total++; if (cap[0][15:0] !== 16'h4000) begin bad++; $display("FAIL i2s_slot0 got=%h want=4000", cap[0][15:0]); end
    total++; if (cap[1][15:0] !== 16'h4080) begin bad++; $display("FAIL i2s_slot1 got=%h want=4080", cap[1][15:0]); end
    total++; if (uf_cnt != base) begin bad++; $display("FAIL i2s_uf got=%0d want=0", uf_cnt - base); end
    stop_block();
  endtask

  task automatic test_underflow();
    int base;
    left_justified = 1'b1; sample_size = 6'd0; channels = 2'b11;
    base = uf_cnt;
    en = 1'b1;
    @(negedge clk);
    run_slots(4, 16);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (cap[i][15:0] !== 16'h0) begin bad++; $display("FAIL uf_slot%0d got=%h want=0000", i, cap[i][15:0]); end
    end
    total++; if (uf_cnt - base != 4) begin bad++; $display("FAIL uf_count got=%0d want=4", uf_cnt - base); end
    stop_block();
  endtask

  task automatic test_left_only();
    logic [15:0] words [3];
    logic [15:0] want;
    logic        ws0;
    int          k, base;
    words = '{16'hC3A5, 16'h5A3C, 16'h9001};
    left_justified = 1'b1; sample_size = 6'd16; channels = 2'b10;
    for (int i = 0; i < 3; i++) txq.push_back({16'h0, words[i]});
    base = uf_cnt;
    ws0 = ~ws;
    repeat (4) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    run_slots(6, 16);
    k = 0;
    for (int s = 0; s < 6; s++) begin
      if ((ws0 ^ s[0]) == 1'b0) begin want = words[k]; k++; end
      else want = 16'h0;
      total++;
      if (cap[s][15:0] !== want) begin bad++; $display("FAIL left_slot%0d got=%h want=%h", s, cap[s][15:0], want); end
    end
    total++; if (uf_cnt != base) begin bad++; $display("FAIL left_uf got=%0d want=0", uf_cnt - base); end
    total++; if (tx_ready !== 1'b1) begin bad++; $display("FAIL left_drained got=%b want=1", tx_ready); end
    stop_block();
  endtask

  task automatic test_truncate();
    int base;
    left_justified = 1'b1; sample_size = 6'd40; channels = 2'b11;  // >32 acts as 32
    txq.push_back(32'hFFFF0000); txq.push_back(32'hA5C31234);
    base = uf_cnt;
    repeat (4) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    run_slots(2, 16);
    total++; if (cap[0][15:0] !== 16'hFFFF) begin bad++; $display("FAIL trunc_slot0 got=%h want=ffff", cap[0][15:0]); end
    total++; if (cap[1][15:0] !== 16'hA5C3) begin bad++; $display("FAIL trunc_slot1 got=%h want=a5c3", cap[1][15:0]); end
    total++; if (uf_cnt != base) begin bad++; $display("FAIL trunc_uf got=%0d want=0", uf_cnt - base); end
    stop_block();
  endtask

  task automatic test_en_drop();
    left_justified = 1'b1; sample_size = 6'd16; channels = 2'b11;
    txq.push_back(32'h1357); txq.push_back(32'h2468); txq.push_back(32'h3579);
    repeat (4) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    fork
      run_slots(3, 16);
      begin
        // Drop en in slot 1 after four bits went out, re-enable mid-slot
        repeat (316) @(negedge clk);
        en = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (sd !== 1'b0) begin bad++; $display("FAIL endrop_sd got=%b want=0", sd); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL endrop_busy got=%b want=0", busy); end
        repeat (384 - 318) @(negedge clk);
        en = 1'b1;
      end
    join
    total++; if (cap[0][15:0] !== 16'h1357) begin bad++; $display("FAIL endrop_slot0 got=%h want=1357", cap[0][15:0]); end
    total++; if (cap[1][15:0] !== 16'h2000) begin bad++; $display("FAIL endrop_slot1 got=%h want=2000", cap[1][15:0]); end
    total++; if (cap[2][15:0] !== 16'h3579) begin bad++; $display("FAIL endrop_slot2 got=%h want=3579", cap[2][15:0]); end
    stop_block();
  endtask

  task automatic test_reset_mid();
    int sr;
    left_justified = 1'b1; sample_size = 6'd16; channels = 2'b11;
    sr = (ws == 1'b1) ? 0 : 1;  // reset lands in a ws=0 slot
    en = 1'b1;
    @(negedge clk);
    fork
      run_slots(sr + 2, 16);
      begin
        repeat (1 + 256 * sr + 66) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        total++; if (sd !== 1'b0) begin bad++; $display("FAIL rstmid_sd got=%b want=0", sd); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        total++; if (tx_ready !== 1'b0) begin bad++; $display("FAIL rstmid_ready got=%b want=0", tx_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        txq.push_back(32'h0000C0DE);
      end
    join
    total++; if (cap[sr+1][15:0] !== 16'hC0DE) begin bad++; $display("FAIL rstmid_word got=%h want=c0de", cap[sr+1][15:0]); end
    stop_block();
  endtask

  initial begin
    sck = 1'b1; ws = 1'b0; en = 1'b0;
    left_justified = 1'b1; sample_size = 6'd16; channels = 2'b11;
    test_reset();
    test_lj_stereo();
    test_i2s_mode();
    test_underflow();
    test_left_only();
    test_truncate();
    test_en_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
